sid_filter_sequencer: RTL and testbench

- Controller that paces and configures the digital SID filter/mixer.
- Generates the filter's clock-enable strobe and drives its reset.
- Holds CPU-written filter registers in a shadow set and commits them atomically at each sample-frame boundary.
- Captures each finished mixed sample into a small FIFO with a valid/ready handshake toward the DAC/PWM stage.

---
 rtl/sid_ctrl_pkg.sv | 19 +
 rtl/sid_sample_fifo.sv | 54 +++++
 rtl/sid_filter_sequencer.sv | 150 +++++++++++++++
 tb/tb_sid_filter_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_ctrl_pkg.sv
// Shared constants and types for the SID filter sequencer.
package sid_ctrl_pkg;

    localparam logic [1:0] ADDR_FC_LO    = 2'd0;
    localparam logic [1:0] ADDR_FC_HI    = 2'd1;
    localparam logic [1:0] ADDR_RES_FILT = 2'd2;
    localparam logic [1:0] ADDR_MODE_VOL = 2'd3;

    localparam int unsigned SMP_W = 15;
    localparam int unsigned FC_W  = 11;
    localparam int unsigned REG_W = 8;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/sid_sample_fifo.sv
// Small synchronous FIFO holding finished mixed samples for the DAC/PWM stage.
module sid_sample_fifo
    import sid_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [SMP_W-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [SMP_W-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [SMP_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A push into a full FIFO only lands when the head leaves on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sid_filter_sequencer.sv
// Paces the SID filter, commits shadowed config at frame boundaries and queues mixed samples.
module sid_filter_sequencer
    import sid_ctrl_pkg::*;
#(
    parameter int unsigned DIV        = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic             filt_clk_enable,
    output logic             filt_rst,
    input  logic             filt_sample_ready,
    input  logic [SMP_W-1:0] filt_sample,
    output logic [FC_W-1:0]  reg_fc,
    output logic [REG_W-1:0] res_filt,
    output logic [REG_W-1:0] mode_vol,
    output logic             smp_valid,
    output logic [SMP_W-1:0] smp_data,
    input  logic             smp_ready,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] div_cnt;
    state_t           state;
    state_t           state_next;
    logic             boundary_c;
    logic             commit_c;
    logic             capture_c;
    logic             pop_c;
    logic             overrun_set_c;
    logic             fifo_full;
    logic             fifo_empty;

    logic [FC_W-1:0]  sh_fc,      sh_fc_next;
    logic [REG_W-1:0] sh_res,     sh_res_next;
    logic [REG_W-1:0] sh_mode,    sh_mode_next;

    // Strobe is a registered compare, so it trails the counter by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt         <= '0;
            filt_clk_enable <= 1'b0;
        end else begin
            filt_clk_enable <= (div_cnt == CNT_W'(DIV - 1));
            div_cnt         <= (div_cnt == CNT_W'(DIV - 1)) ? '0 : div_cnt + CNT_W'(1);
        end
    end

    assign boundary_c = filt_clk_enable && filt_sample_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            filt_rst <= 1'b1;
        end else begin
            state    <= state_next;
            filt_rst <= (state_next == INIT);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (filt_clk_enable) state_next = PRIME;
            PRIME:   if (boundary_c)      state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // The first boundary after filter reset commits config but its sample is junk.
    always_comb begin
        commit_c  = 1'b0;
        capture_c = 1'b0;
        case (state)
            PRIME: commit_c = boundary_c;
            RUN: begin
                commit_c  = boundary_c;
                capture_c = boundary_c;
            end
            default: ;
        endcase
    end

    always_comb begin
        sh_fc_next   = sh_fc;
        sh_res_next  = sh_res;
        sh_mode_next = sh_mode;
        if (cfg_we) begin
            case (cfg_addr)
                ADDR_FC_LO:    sh_fc_next[2:0]  = cfg_wdata[2:0];
                ADDR_FC_HI:    sh_fc_next[10:3] = cfg_wdata;
                ADDR_RES_FILT: sh_res_next      = cfg_wdata;
                ADDR_MODE_VOL: sh_mode_next     = cfg_wdata;
                default: ;
            endcase
        end
    end

    // Live registers take the post-write shadow so a same-edge write is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_fc    <= '0;
            sh_res   <= '0;
            sh_mode  <= '0;
            reg_fc   <= '0;
            res_filt <= '0;
            mode_vol <= '0;
        end else begin
            sh_fc   <= sh_fc_next;
            sh_res  <= sh_res_next;
            sh_mode <= sh_mode_next;
            if (commit_c) begin
                reg_fc   <= sh_fc_next;
                res_filt <= sh_res_next;
                mode_vol <= sh_mode_next;
            end
        end
    end

    assign pop_c         = smp_valid && smp_ready;
    assign overrun_set_c = capture_c && fifo_full && !pop_c;
    assign smp_valid     = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst)                overrun <= 1'b0;
        else if (overrun_set_c) overrun <= 1'b1;
        else if (ovr_clr)       overrun <= 1'b0;
    end

    sid_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture_c),
        .push_data (filt_sample),
        .pop       (pop_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (smp_data)
    );

endmodule

// File: tb/tb_sid_filter_sequencer.sv
// Bench for sid_filter_sequencer: cycle reference model, sample scoreboard and directed scenarios.
module tb_sid_filter_sequencer;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_wdata = 8'd0;
    logic        filt_clk_enable;
    logic        filt_rst;
    logic        filt_sample_ready = 1'b0;
    logic [14:0] filt_sample = 15'd0;
    logic [10:0] reg_fc;
    logic [7:0]  res_filt;
    logic [7:0]  mode_vol;
    logic        smp_valid;
    logic [14:0] smp_data;
    logic        smp_ready = 1'b0;
    logic        overrun;
    logic        ovr_clr = 1'b0;

    sid_filter_sequencer #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_we            (cfg_we),
        .cfg_addr          (cfg_addr),
        .cfg_wdata         (cfg_wdata),
        .filt_clk_enable   (filt_clk_enable),
        .filt_rst          (filt_rst),
        .filt_sample_ready (filt_sample_ready),
        .filt_sample       (filt_sample),
        .reg_fc            (reg_fc),
        .res_filt          (res_filt),
        .mode_vol          (mode_vol),
        .smp_valid         (smp_valid),
        .smp_data          (smp_data),
        .smp_ready         (smp_ready),
        .overrun           (overrun),
        .ovr_clr           (ovr_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (0 = INIT, 1 = PRIME, 2 = RUN) and filter step model.
    int          m_cnt = 0;
    logic        m_en = 1'b0;
    int          m_st = 0;
    logic        m_frst = 1'b1;
    int          step = 5;
    logic [10:0] m_sfc = '0, m_fc = '0;
    logic [7:0]  m_srf = '0, m_rf = '0, m_smv = '0, m_mv = '0;
    logic        m_ovr = 1'b0;
    logic [14:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: update the model from pre-edge inputs, then compare after the edge.
    task automatic tick();
        logic bnd, pop, full, old_en, old_frst;
        bnd      = m_en && (step == 0);
        old_en   = m_en;
        old_frst = m_frst;
        if (rst) begin
            m_cnt = 0; m_en = 1'b0; m_st = 0;
            m_sfc = '0; m_srf = '0; m_smv = '0;
            m_fc = '0; m_rf = '0; m_mv = '0;
            m_ovr = 1'b0;
            sb_q.delete();
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: m_sfc[2:0]  = cfg_wdata[2:0];
                    2'd1: m_sfc[10:3] = cfg_wdata;
                    2'd2: m_srf       = cfg_wdata;
                    default: m_smv    = cfg_wdata;
                endcase
            end
            full = (sb_q.size() == DEPTH);
            pop  = (sb_q.size() != 0) && smp_ready;
            if (pop) begin
                check_eq("pop_data", 32'(smp_data), 32'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (bnd && m_st == 2) begin
                if (full && !pop) m_ovr = 1'b1;
                else              sb_q.push_back(filt_sample);
            end
            if (!(bnd && m_st == 2 && full && !pop) && ovr_clr) m_ovr = 1'b0;
            if (bnd && m_st != 0) begin
                m_fc = m_sfc; m_rf = m_srf; m_mv = m_smv;
            end
            if (m_st == 0 && m_en)     m_st = 1;
            else if (m_st == 1 && bnd) m_st = 2;
            m_en  = (m_cnt == DIV - 1);
            m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
        end
        if (old_en) step = old_frst ? 0 : (step + 1) % 8;
        m_frst = (m_st == 0);

        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        ovr_clr = 1'b0;
        filt_sample_ready = (step == 0);

        check_eq("strobe",    32'(filt_clk_enable), 32'(m_en));
        check_eq("filt_rst",  32'(filt_rst),        32'(m_frst));
        check_eq("reg_fc",    32'(reg_fc),          32'(m_fc));
        check_eq("res_filt",  32'(res_filt),        32'(m_rf));
        check_eq("mode_vol",  32'(mode_vol),        32'(m_mv));
        check_eq("smp_valid", 32'(smp_valid),       32'(sb_q.size() != 0));
        check_eq("overrun",   32'(overrun),         32'(m_ovr));
        if (sb_q.size() != 0) check_eq("smp_head", 32'(smp_data), 32'(sb_q[0]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run until the current cycle is a PRIME/RUN frame boundary (bounded).
    task automatic to_boundary(input string tag);
        int n;
        n = 0;
        while (!(m_en && step == 0 && m_st != 0) && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    endtask

    initial begin
        logic [14:0] drain_exp [4];
        drain_exp[0] = 15'h101; drain_exp[1] = 15'h102;
        drain_exp[2] = 15'h103; drain_exp[3] = 15'h200;

        // Reset and INIT: first strobe four cycles after release.
        rst = 1'b1;
        ticks(2);
        check_eq("rst_smp_valid", 32'(smp_valid), 32'd0);
        check_eq("rst_smp_data",  32'(smp_data),  32'd0);
        rst = 1'b0;
        ticks(3);
        check_eq("no_strobe_c3", 32'(filt_clk_enable), 32'd0);
        tick();
        check_eq("first_strobe",   32'(filt_clk_enable), 32'd1);
        check_eq("rst_held_strobe", 32'(filt_rst),       32'd1);
        tick();
        check_eq("rst_released", 32'(filt_rst), 32'd0);

        // PRIME boundary: sample must be discarded.
        filt_sample = 15'h7777;
        to_boundary("reach_prime_bnd");
        tick();
        check_eq("prime_discard", 32'(smp_valid), 32'd0);
        check_eq("prime_fc",      32'(reg_fc),    32'd0);
        ticks(6);

        // Atomic commit of mid-frame writes plus a same-edge write.
        cfg_write(2'd1, 8'hAB);
        tick();
        cfg_write(2'd0, 8'h05);
        tick();
        cfg_write(2'd2, 8'h3C);
        ticks(3);
        check_eq("fc_held", 32'(reg_fc), 32'd0);
        to_boundary("reach_commit_bnd");
        cfg_write(2'd3, 8'h1F);
        filt_sample = 15'h4123;
        smp_ready   = 1'b1;
        tick();
        check_eq("fc_commit",  32'(reg_fc),   32'h55D);
        check_eq("rf_commit",  32'(res_filt), 32'h3C);
        check_eq("mv_same_edge", 32'(mode_vol), 32'h1F);
        check_eq("cap_valid",  32'(smp_valid), 32'd1);
        check_eq("cap_data",   32'(smp_data),  32'h4123);
        filt_sample = 15'h0;
        ticks(3);

        // Backpressure: five frames into a depth-4 FIFO.
        smp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            to_boundary("reach_bp_bnd");
            filt_sample = 15'(32'h100 + i);
            tick();
        end
        check_eq("ovr_set", 32'(overrun),  32'd1);
        check_eq("bp_head", 32'(smp_data), 32'h100);
        ovr_clr = 1'b1;
        tick();
        check_eq("ovr_clr", 32'(overrun), 32'd0);

        // Dropped push and clear on the same edge: set wins.
        to_boundary("reach_prio_bnd");
        filt_sample = 15'h1FF;
        ovr_clr = 1'b1;
        tick();
        check_eq("ovr_priority", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        tick();

        // Push and pop together while full.
        to_boundary("reach_pp_bnd");
        filt_sample = 15'h200;
        smp_ready   = 1'b1;
        tick();
        smp_ready = 1'b0;
        check_eq("pp_ovr",  32'(overrun),  32'd0);
        check_eq("pp_head", 32'(smp_data), 32'h101);
        ticks(2);
        smp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_order", 32'(smp_data), 32'(drain_exp[i]));
            tick();
        end
        check_eq("drained", 32'(smp_valid), 32'd0);
        smp_ready = 1'b0;

        // Reset mid-operation with three samples queued.
        for (int i = 0; i < 3; i++) begin
            to_boundary("reach_q3_bnd");
            filt_sample = 15'(32'h300 + i);
            tick();
        end
        check_eq("q3_valid", 32'(smp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_valid", 32'(smp_valid), 32'd0);
        check_eq("mid_rst_data",  32'(smp_data),  32'd0);
        check_eq("mid_rst_ovr",   32'(overrun),   32'd0);
        check_eq("mid_rst_frst",  32'(filt_rst),  32'd1);
        check_eq("mid_rst_fc",    32'(reg_fc),    32'd0);
        check_eq("mid_rst_mv",    32'(mode_vol),  32'd0);

        // Restart: PRIME frame then a fresh capture.
        filt_sample = 15'h0BAD;
        to_boundary("reach_prime2_bnd");
        tick();
        check_eq("prime2_discard", 32'(smp_valid), 32'd0);
        to_boundary("reach_run2_bnd");
        filt_sample = 15'h0ABC;
        smp_ready   = 1'b1;
        tick();
        check_eq("restart_cap", 32'(smp_data), 32'h0ABC);
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
